// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C register-memory target.
// Holds the protocol state enumeration, parameter legality helpers and the
// majority vote used by the optional glitch filter.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    OFFS,
    OFFS_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_t;

  // The offset phase is either one or two bytes long.
  function automatic bit offset_bytes_legal(input int n);
    return (n == 1) || (n == 2);
  endfunction

  // Memory depth must be a power of two between 16 and 65536 bytes.
  function automatic bit depth_legal(input int d);
    return (d >= 16) && (d <= 65536) && ((d & (d - 1)) == 0);
  endfunction

  // Two-out-of-three vote over consecutive samples.
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: brings SCL/SDA into the clk domain and flags bus events.
// Two-flop synchronisers (reset to 1 = idle bus), an optional 3-sample
// majority filter enabled by I2C_SLAVE_GLITCH_FILTER_EN, and START/STOP and
// SCL edge detection on the cleaned signals.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_f;
  logic       sda_f;
  logic       scl_prev;
  logic       sda_prev;

  // Two-stage synchronisers for the asynchronous bus pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_hist;
  logic [2:0] sda_hist;

  // Sample history for the majority vote; a one-clk pulse never fills two slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
    end
  end

  assign scl_f = maj3(scl_hist);
  assign sda_f = maj3(sda_hist);
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  // Previous cleaned levels for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_prev;
  assign scl_fall  = ~scl_f & scl_prev;
  assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;
  assign sda_s     = sda_f;

endmodule

// File: rtl/i2c_slave_regmem.sv
// i2c_slave_regmem: I2C target exposing a byte memory with a fabric port.
// The master writes an offset (1 or 2 bytes), then data bytes, or reads from
// the current offset after a repeated START. Offsets wrap at DEPTH.
// Optional input glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_regmem
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR   = 7'h36,
  parameter int         OFFSET_BYTES = 2,
  parameter int         DEPTH        = 256,
  localparam int        AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  if (!offset_bytes_legal(OFFSET_BYTES)) begin : g_bad_offset_bytes
    $error("OFFSET_BYTES must be 1 or 2");
  end
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("DEPTH must be a power of two from 16 to 65536");
  end

  localparam logic [1:0] OFFS_LAST = 2'(OFFSET_BYTES);

  logic          scl_rise, scl_fall, start_det, stop_det, sda_s;
  i2c_state_t    state, state_nxt;
  logic [3:0]    bit_cnt;
  logic [7:0]    rx_byte, tx_byte, rd_byte;
  logic          ack_q;
  logic [1:0]    offs_cnt;
  logic [AW-1:0] offs_acc, offset, offset_inc;
  logic          sda_oe_nxt, mem_we, load_tx, byte_done, addr_match;
  logic [7:0]    mem [DEPTH];

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign offset_inc = offset + AW'(1);
  assign byte_done  = (bit_cnt == 4'd8);
  assign addr_match = (rx_byte[7:1] == SLAVE_ADDR);
  assign rd_byte    = (state == RDATA_ACK) ? mem[offset_inc] : mem[offset];

  // Protocol state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: STOP and START override everything, byte phases advance on SCL fall.
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = IDLE;
    end else if (start_det) begin
      state_nxt = ADDR;
    end else if (scl_fall) begin
      case (state)
        ADDR:      if (byte_done) state_nxt = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK:  state_nxt = rx_byte[0] ? RDATA : OFFS;
        OFFS:      if (byte_done) state_nxt = OFFS_ACK;
        OFFS_ACK:  state_nxt = (offs_cnt == OFFS_LAST) ? WDATA : OFFS;
        WDATA:     if (byte_done) state_nxt = WDATA_ACK;
        WDATA_ACK: state_nxt = WDATA;
        RDATA:     if (byte_done) state_nxt = RDATA_ACK;
        RDATA_ACK: state_nxt = ack_q ? IGNORE : RDATA;
        default:   state_nxt = state;
      endcase
    end
  end

  // Output decode: next SDA drive and the write/load strobes taken at SCL fall.
  always_comb begin
    sda_oe_nxt = sda_oe;
    mem_we     = 1'b0;
    load_tx    = 1'b0;
    if (start_det || stop_det) begin
      sda_oe_nxt = 1'b0;
    end else if (scl_fall) begin
      case (state)
        ADDR:        sda_oe_nxt = byte_done && addr_match;
        OFFS, WDATA: sda_oe_nxt = byte_done;
        ADDR_ACK: begin
          load_tx    = rx_byte[0];
          sda_oe_nxt = rx_byte[0] && !rd_byte[7];
        end
        WDATA_ACK: begin
          mem_we     = 1'b1;
          sda_oe_nxt = 1'b0;
        end
        RDATA:       sda_oe_nxt = !byte_done && !tx_byte[6];
        RDATA_ACK: begin
          load_tx    = !ack_q;
          sda_oe_nxt = !ack_q && !rd_byte[7];
        end
        default:     sda_oe_nxt = 1'b0;
      endcase
    end
  end

  // Datapath: bit counting, shifting, offset tracking, write reporting and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_byte  <= '0;
      tx_byte  <= '0;
      ack_q    <= 1'b1;
      offs_cnt <= '0;
      offs_acc <= '0;
      offset   <= '0;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
    end else begin
      sda_oe   <= sda_oe_nxt;
      wr_valid <= 1'b0;
      if (start_det) begin
        bit_cnt  <= '0;
        offs_cnt <= '0;
        offs_acc <= '0;
      end else if (stop_det) begin
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR, OFFS, WDATA: begin
            rx_byte <= {rx_byte[6:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
          end
          RDATA:     bit_cnt <= bit_cnt + 4'd1;
          RDATA_ACK: ack_q <= sda_s;
          default:   ;
        endcase
      end else if (scl_fall) begin
        if (state_nxt != state) bit_cnt <= '0;
        if (load_tx) tx_byte <= rd_byte;
        else if (state == RDATA && !byte_done) tx_byte <= {tx_byte[6:0], 1'b0};
        if (state == ADDR && byte_done && addr_match) busy <= 1'b1;
        if (state == OFFS && byte_done) begin
          offs_acc <= AW'({offs_acc, rx_byte});
          offs_cnt <= offs_cnt + 2'd1;
        end
        if (state == OFFS_ACK && offs_cnt == OFFS_LAST) offset <= offs_acc;
        if (mem_we) begin
          wr_valid <= 1'b1;
          wr_addr  <= offset;
          wr_data  <= rx_byte;
          offset   <= offset_inc;
        end
        if (state == RDATA_ACK && !ack_q) offset <= offset_inc;
      end
    end
  end

  // Memory array, never cleared; the I2C write is ordered last so it wins a collision.
  always_ff @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_wdata;
    if (mem_we)  mem[offset]    <= rx_byte;
  end

  // Registered fabric read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) host_rdata <= '0;
    else     host_rdata <= mem[host_addr];
  end

endmodule

// File: tb/tb_i2c_slave_regmem.sv
// tb_i2c_slave_regmem: directed and randomized I2C master bench with a
// byte-array reference model of the target memory.
module tb_i2c_slave_regmem;
  import i2c_pkg::*;

  localparam int         DEPTH = 256;
  localparam int         AW    = 8;
  localparam logic [6:0] SLV   = 7'h36;
  localparam int         Q     = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          scl_m, sda_m, sda_line;
  logic          sda_oe, host_we, wr_valid, busy;
  logic [AW-1:0] host_addr, wr_addr;
  logic [7:0]    host_wdata, host_rdata, wr_data;

  int            total = 0;
  int            bad   = 0;
  logic [7:0]    ref_mem [DEPTH];
  logic [15:0]   wr_seen [$];
  int            oe_cnt   = 0;
  int            busy_cnt = 0;
  logic [7:0]    dq [$];

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regmem #(.SLAVE_ADDR(SLV), .OFFSET_BYTES(2), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl_m),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  // Observe write reports and drive/busy activity away from the active edge.
  always @(negedge clk) begin
    if (wr_valid) wr_seen.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    sda_m = b; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    if (glitch) begin
      scl_m = 1'b0; wait_clk(1);
      scl_m = 1'b1; wait_clk(Q - 1);
    end else begin
      wait_clk(Q);
    end
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_line; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == gbit);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack, 1'b0);
  endtask

  // Full write transaction; model: byte i lands at (off+i) mod DEPTH.
  task automatic apply_stimulus(input logic [6:0] a, input int off, input logic [7:0] d[$],
                                input int gbit, input string tag);
    logic        ack, exp_nack;
    int          base;
    logic [15:0] o16;
    base     = wr_seen.size();
    exp_nack = (a != SLV);
    o16      = 16'(off);
    i2c_start;
    send_byte({a, 1'b0}, -1, ack);
    check_output({tag, " addr ack"}, ack, exp_nack);
    check_output({tag, " busy"}, busy, !exp_nack);
    send_byte(o16[15:8], -1, ack);
    check_output({tag, " offs hi ack"}, ack, exp_nack);
    send_byte(o16[7:0], -1, ack);
    check_output({tag, " offs lo ack"}, ack, exp_nack);
    for (int i = 0; i < d.size(); i++) begin
      send_byte(d[i], (i == 0) ? gbit : -1, ack);
      check_output({tag, " data ack"}, ack, exp_nack);
      if (!exp_nack) ref_mem[(off + i) % DEPTH] = d[i];
    end
    i2c_stop;
    check_output({tag, " busy after stop"}, busy, 1'b0);
    check_output({tag, " wr count"}, wr_seen.size() - base, exp_nack ? 0 : d.size());
    if (!exp_nack)
      for (int i = 0; i < d.size() && base + i < wr_seen.size(); i++)
        check_output({tag, " wr event"}, wr_seen[base + i], {8'((off + i) % DEPTH), d[i]});
  endtask

  // Offset write, repeated START, read n bytes (ACK..NACK), then one ignored byte.
  task automatic i2c_read(input int off, input int n, input string tag);
    logic        ack;
    logic [7:0]  b;
    logic [15:0] o16;
    o16 = 16'(off);
    i2c_start;
    send_byte({SLV, 1'b0}, -1, ack);
    check_output({tag, " addr ack"}, ack, 1'b0);
    send_byte(o16[15:8], -1, ack);
    send_byte(o16[7:0], -1, ack);
    check_output({tag, " offs ack"}, ack, 1'b0);
    i2c_start;
    send_byte({SLV, 1'b1}, -1, ack);
    check_output({tag, " raddr ack"}, ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      recv_byte(b, i == n - 1);
      check_output({tag, " data"}, b, ref_mem[(off + i) % DEPTH]);
    end
    recv_byte(b, 1'b1);
    check_output({tag, " ignored after nack"}, b, 8'hFF);
    i2c_stop;
  endtask

  task automatic host_check(input int a, input string tag);
    host_addr = AW'(a);
    wait_clk(2);
    check_output(tag, host_rdata, ref_mem[a]);
  endtask

  initial begin
    int          oe_base, busy_base, wr_base, off, n, target;
    logic [7:0]  cd;
    logic [6:0]  a7;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    wait_clk(3);
    check_output("reset sda_oe", sda_oe, 1'b0);
    check_output("reset wr_valid", wr_valid, 1'b0);
    check_output("reset busy", busy, 1'b0);
    check_output("reset host_rdata", host_rdata, 8'h00);
    rst = 1'b0;
    wait_clk(2);

    // Give every location a known value through the fabric port.
    for (int a = 0; a < DEPTH; a++) begin
      host_addr  = AW'(a);
      host_wdata = 8'($urandom);
      host_we    = 1'b1;
      ref_mem[a] = host_wdata;
      wait_clk(1);
    end
    host_we = 1'b0;
    for (int k = 0; k < 3; k++) host_check($urandom_range(0, DEPTH - 1), "host readback");

    dq = {8'hA5, 8'h3C};
    apply_stimulus(SLV, 16'h0010, dq, -1, "write10");
    host_check(16'h10, "host mem10");
    host_check(16'h11, "host mem11");
    i2c_read(16'h0010, 2, "read10");

    oe_base = oe_cnt; busy_base = busy_cnt;
    apply_stimulus(7'h37, 16'h0020, dq, -1, "wrong addr");
    check_output("wrong addr sda_oe cycles", oe_cnt - oe_base, 0);
    check_output("wrong addr busy cycles", busy_cnt - busy_base, 0);

    dq = {8'($urandom), 8'($urandom), 8'($urandom)};
    apply_stimulus(SLV, DEPTH - 1, dq, -1, "wrap");
    host_check(DEPTH - 1, "wrap host ff");
    host_check(0, "wrap host 00");
    host_check(1, "wrap host 01");

    // STOP in the middle of a data byte must not write.
    wr_base = wr_seen.size();
    begin
      logic ack;
      i2c_start;
      send_byte({SLV, 1'b0}, -1, ack);
      send_byte(8'h00, -1, ack);
      send_byte(8'h40, -1, ack);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
      i2c_stop;
    end
    check_output("stop4 wr count", wr_seen.size() - wr_base, 0);
    check_output("stop4 sda_oe", sda_oe, 1'b0);
    check_output("stop4 busy", busy, 1'b0);
    check_output("stop4 state", 32'(dut.state), 32'(IDLE));

    // Reset while the target is driving ACK, then the bus is ignored until START.
    i2c_start;
    a7 = SLV;
    for (int i = 6; i >= 0; i--) send_bit(a7[i], 1'b0);
    send_bit(1'b0, 1'b0);
    wait_clk(1);
    check_output("pre-reset ack drive", sda_oe, 1'b1);
    #2 rst = 1'b1;
    #1 check_output("async reset release", sda_oe, 1'b0);
    wait_clk(2);
    rst = 1'b0;
    oe_base = oe_cnt; busy_base = busy_cnt;
    for (int i = 0; i < 9; i++) send_bit(1'b0, 1'b0);
    check_output("post-reset ignore oe", oe_cnt - oe_base, 0);
    check_output("post-reset ignore busy", busy_cnt - busy_base, 0);
    i2c_stop;

    // Host and I2C hit the same byte in the same cycle: I2C value must stick.
    target = $urandom_range(0, DEPTH - 1);
    cd = 8'($urandom);
    dq = {cd};
    host_addr = AW'(target); host_wdata = ~cd; host_we = 1'b1;
    fork
      apply_stimulus(SLV, target, dq, -1, "collide");
      begin
        for (int k = 0; k < 3000; k++) begin
          @(negedge clk);
          if (wr_valid) begin
            host_we = 1'b0;
            break;
          end
        end
      end
    join
    host_we = 1'b0;
    host_check(target, "collide host read");

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    dq = {8'($urandom), 8'($urandom)};
    apply_stimulus(SLV, 16'h0030, dq, 3, "glitch");
    i2c_read(16'h0030, 2, "glitch read");
`endif

    // Randomized write/read-back rounds against the model.
    for (int r = 0; r < 5; r++) begin
      off = $urandom_range(0, DEPTH - 1);
      n   = $urandom_range(1, 4);
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
      apply_stimulus(SLV, off, dq, -1, "rand write");
      i2c_read(off, n, "rand read");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
